// File: rtl/tt_um_nibble_sub8_pkg.sv
// Shared definitions for the nibble-serial subtractor tile: FSM encoding,
// uio bit positions and the fixed output-enable mask.
package tt_um_nibble_sub8_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int LOAD_A = 0;
  localparam int LOAD_B = 1;
  localparam int START  = 2;
  localparam int OVF    = 4;
  localparam int BORROW = 5;
  localparam int DONE   = 6;
  localparam int BUSY   = 7;

  localparam logic [7:0] UIO_OE_MASK = 8'hF0;

endpackage

// File: rtl/tt_um_nibble_sub8_nibble_add4.sv
// Combinational 4-bit ripple-carry adder, shared by both nibbles of the subtractor.
module nibble_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] carry;

  always_comb begin
    carry[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[4];
  end

endmodule

// File: rtl/tt_um_nibble_sub8.sv
// Two-cycle 8-bit subtractor A - B: one 4-bit adder processes the low nibble,
// then the high nibble, with the carry registered in between.
module tt_um_nibble_sub8
  import tt_um_nibble_sub8_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_t     state;
  logic [7:0] a_reg, b_reg;
  logic [7:0] op_a, op_b;
  logic [7:0] diff;
  logic       c_reg, borrow, ovf;

  logic [3:0] add_a, add_b, add_sum;
  logic       add_cin, add_cout;
  logic       load_a, load_b, start, can_load;

  logic unused_inputs;
  assign unused_inputs = &{ena, uio_in[7:3], 1'b0};

  assign load_a   = uio_in[LOAD_A];
  assign load_b   = uio_in[LOAD_B];
  assign start    = uio_in[START];
  assign can_load = (state == S_IDLE) || (state == S_DONE);

  // Subtraction as a + ~b + 1: the +1 enters as the low-nibble carry-in.
  always_comb begin
    add_a   = op_a[3:0];
    add_b   = ~op_b[3:0];
    add_cin = 1'b1;
    if (state == S_HI) begin
      add_a   = op_a[7:4];
      add_b   = ~op_b[7:4];
      add_cin = c_reg;
    end
  end

  nibble_add4 u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // op_a/op_b snapshot the operands at start, so a load on the same edge
  // only affects the following operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      op_a   <= '0;
      op_b   <= '0;
      diff   <= '0;
      c_reg  <= 1'b0;
      borrow <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (can_load && load_a) a_reg <= ui_in;
      if (can_load && load_b) b_reg <= ui_in;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            op_a  <= a_reg;
            op_b  <= b_reg;
            state <= S_LO;
          end else begin
            state <= S_IDLE;
          end
        end
        S_LO: begin
          diff[3:0] <= add_sum;
          c_reg     <= add_cout;
          state     <= S_HI;
        end
        S_HI: begin
          diff[7:4] <= add_sum;
          borrow    <= ~add_cout;
          ovf       <= (op_a[7] ^ op_b[7]) & (op_a[7] ^ add_sum[3]);
          state     <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign uo_out  = diff;
  assign uio_out = {(state == S_LO) || (state == S_HI), state == S_DONE, borrow, ovf, 4'b0000};
  assign uio_oe  = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_um_nibble_sub8.sv
// Directed self-checking bench for tt_um_nibble_sub8 with hand-computed results.
module tb_tt_um_nibble_sub8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = '0;
  logic [7:0] uio_in = '0;
  logic [7:0] uo_out, uio_out, uio_oe;

  int checks = 0;
  int errors = 0;

  tt_um_nibble_sub8 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled at the next falling edge.
  task automatic applyStimulus(input logic ld_a, input logic ld_b, input logic st,
                               input logic [7:0] data);
    ui_in  = data;
    uio_in = {5'b00000, st, ld_b, ld_a};
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic loadOperands(input logic [7:0] a, input logic [7:0] b);
    applyStimulus(1'b1, 1'b0, 1'b0, a);
    applyStimulus(1'b0, 1'b1, 1'b0, b);
  endtask

  // Start with current operands and check the full busy/done timeline.
  task automatic startAndCheck(input string tag, input logic [7:0] exp_diff,
                               input logic exp_borrow, input logic exp_ovf);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput({tag, " busy k+1"}, uio_out[7:6], 2'b10);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput({tag, " busy k+2"}, uio_out[7:6], 2'b10);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput({tag, " done"}, uio_out[7:6], 2'b01);
    checkOutput({tag, " diff"}, uo_out, exp_diff);
    checkOutput({tag, " borrow/ovf"}, uio_out[5:4], {exp_borrow, exp_ovf});
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput({tag, " idle"}, uio_out[7:6], 2'b00);
    checkOutput({tag, " held"}, uo_out, exp_diff);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("reset uo_out", uo_out, 8'h00);
    checkOutput("reset uio_out", uio_out, 8'h00);
    checkOutput("uio_oe", uio_oe, 8'hF0);
    rst_n = 1'b1;

    loadOperands(8'h35, 8'h12); startAndCheck("35-12", 8'h23, 1'b0, 1'b0);
    loadOperands(8'h10, 8'h01); startAndCheck("10-01", 8'h0F, 1'b0, 1'b0);
    loadOperands(8'h00, 8'h01); startAndCheck("00-01", 8'hFF, 1'b1, 1'b0);
    loadOperands(8'h80, 8'h01); startAndCheck("80-01", 8'h7F, 1'b0, 1'b1);
    loadOperands(8'h7F, 8'hFF); startAndCheck("7F-FF", 8'h80, 1'b1, 1'b1);
    loadOperands(8'hC8, 8'h38); startAndCheck("C8-38", 8'h90, 1'b0, 1'b0);

    // Loads and start during LO/HI must be ignored.
    loadOperands(8'h55, 8'h22);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hFF);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hFF);
    checkOutput("prot done", uio_out[7:6], 2'b01);
    checkOutput("prot diff", uo_out, 8'h33);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("prot no queue", uio_out[7:6], 2'b00);
    startAndCheck("prot operands kept", 8'h33, 1'b0, 1'b0);

    // Load together with start: this operation still uses the old A.
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h10);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("ldstart old", uo_out, 8'h33);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    startAndCheck("ldstart new 10-22", 8'hEE, 1'b1, 1'b0);

    // Start held high: one result every third cycle.
    loadOperands(8'h35, 8'h12);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
      if (i % 3 == 2) begin
        checkOutput($sformatf("b2b done %0d", i), uio_out[7:6], 2'b01);
        checkOutput($sformatf("b2b diff %0d", i), uo_out, 8'h23);
      end else begin
        checkOutput($sformatf("b2b busy %0d", i), uio_out[7:6], 2'b10);
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("b2b idle", uio_out, 8'h00);

    // Reset while in HI aborts and clears everything.
    loadOperands(8'h80, 8'h01);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("pre-reset busy", uio_out[7:6], 2'b10);
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("midop reset uo_out", uo_out, 8'h00);
    checkOutput("midop reset uio_out", uio_out, 8'h00);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("post reset idle", uio_out, 8'h00);
    loadOperands(8'hC8, 8'h38); startAndCheck("post reset C8-38", 8'h90, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
